display_burst_responder: RTL and testbench

- Memory-side responder for the video display file readers; serves wrapping 4-word burst reads from two requester channels (file 0, file 1).
- Per burst: arbitrates, issues four single-word reads to the SDRAM/RAM backend in wrap order, returns data beats with per-channel valid strobes and a bus acknowledge.
- Sits between the two display file readers and the shared memory backend port.

---
 rtl/display_mem_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 51 +++++
 rtl/display_burst_responder.sv | 160 ++++++++++++++++
 tb/tb_display_burst_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_mem_pkg.sv
// Shared types and constants for the display-file memory responder.
//   burst_state_t : responder FSM states (IDLE, ISSUE, DRAIN)
//   BURST_WORDS   : words per wrapping burst
//   chan_t        : requester channel index (0 = file 0, 1 = file 1)
package display_mem_pkg;

    localparam int BURST_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } burst_state_t;

    typedef logic chan_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter for the display burst responder.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   req[1:0]     : raw request (address strobe) per channel
//   ack[1:0]     : burst acknowledge pulses of the responder
//   grant_valid  : at least one unmasked request present
//   grant_ch     : channel that wins this cycle
// A channel that was just acknowledged is masked for one cycle, because its
// requester only drops the strobe on the edge that follows the acknowledge.
// On a tie the channel not served last wins; after reset channel 0 is favoured.
module rr_arbiter2
    import display_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] ack,
    output logic       grant_valid,
    output chan_t      grant_ch
);

    chan_t      last_reg;
    logic [1:0] blank_reg;
    logic [1:0] req_eff;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg  <= 1'b1;
            blank_reg <= 2'b00;
        end else begin
            blank_reg <= ack;
            if (ack[0]) begin
                last_reg <= 1'b0;
            end else if (ack[1]) begin
                last_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        req_eff     = req & ~blank_reg;
        grant_valid = |req_eff;
        grant_ch    = 1'b0;
        if (req_eff == 2'b11) begin
            grant_ch = ~last_reg;
        end else if (req_eff[1]) begin
            grant_ch = 1'b1;
        end
    end

endmodule

// File: rtl/display_burst_responder.sv
// Memory-side responder serving wrapping 4-word burst reads for the two
// video display file readers.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   req_addr0/1, req_as0/1     : requester start byte address and strobe
//   bus_ack0/1                 : burst acknowledge, pulses with the last beat
//   burstdata_valid0/1         : data beat strobe for the granted channel
//   dout                       : shared data beat
//   mem_addr, mem_rd, mem_ready: backend word read request handshake
//   mem_rdata, mem_rvalid      : backend in-order read return
// Four single-word reads are issued in wrap order inside the 8-byte block,
// and read data is forwarded one cycle after mem_rvalid. Issue and return
// are counted independently so the backend may pipeline up to four reads.
module display_burst_responder #(
    parameter int ADDR_W      = 22,
    parameter int BURST_WORDS = display_mem_pkg::BURST_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic              req_as0,
    output logic              bus_ack0,
    output logic              burstdata_valid0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic              req_as1,
    output logic              bus_ack1,
    output logic              burstdata_valid1,
    output logic [15:0]       dout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid
);

    localparam logic [2:0] BURST_CNT = 3'(BURST_WORDS);

    display_mem_pkg::burst_state_t state_reg, state_next;
    display_mem_pkg::chan_t        ch_reg, ch_next;
    display_mem_pkg::chan_t        grant_ch;
    logic                          grant_valid;

    logic [ADDR_W-4:0] base_reg, base_next;
    logic [1:0]        widx_reg, widx_next;
    logic [2:0]        issue_cnt_reg, issue_cnt_next;
    logic [2:0]        ret_cnt_reg, ret_cnt_next;
    logic [15:0]       dout_reg, dout_next;
    logic [1:0]        beat_reg, beat_next;
    logic [1:0]        ack_reg, ack_next;

    // Bit 0 of the request address selects a byte and is meaningless here.
    logic unused_addr_bits;
    assign unused_addr_bits = req_addr0[0] ^ req_addr1[0];

    rr_arbiter2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         ({req_as1, req_as0}),
        .ack         (ack_reg),
        .grant_valid (grant_valid),
        .grant_ch    (grant_ch)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= display_mem_pkg::IDLE;
            ch_reg        <= 1'b0;
            base_reg      <= '0;
            widx_reg      <= 2'd0;
            issue_cnt_reg <= 3'd0;
            ret_cnt_reg   <= 3'd0;
            dout_reg      <= 16'd0;
            beat_reg      <= 2'b00;
            ack_reg       <= 2'b00;
        end else begin
            state_reg     <= state_next;
            ch_reg        <= ch_next;
            base_reg      <= base_next;
            widx_reg      <= widx_next;
            issue_cnt_reg <= issue_cnt_next;
            ret_cnt_reg   <= ret_cnt_next;
            dout_reg      <= dout_next;
            beat_reg      <= beat_next;
            ack_reg       <= ack_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ch_next        = ch_reg;
        base_next      = base_reg;
        widx_next      = widx_reg;
        issue_cnt_next = issue_cnt_reg;
        ret_cnt_next   = ret_cnt_reg;
        dout_next      = dout_reg;
        beat_next      = 2'b00;
        ack_next       = 2'b00;
        mem_rd         = 1'b0;

        case (state_reg)
            display_mem_pkg::IDLE: begin
                if (grant_valid) begin
                    ch_next        = grant_ch;
                    base_next      = grant_ch ? req_addr1[ADDR_W-1:3] : req_addr0[ADDR_W-1:3];
                    widx_next      = grant_ch ? req_addr1[2:1] : req_addr0[2:1];
                    issue_cnt_next = 3'd0;
                    ret_cnt_next   = 3'd0;
                    state_next     = display_mem_pkg::ISSUE;
                end
            end
            display_mem_pkg::ISSUE: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    widx_next      = widx_reg + 2'd1;
                    issue_cnt_next = issue_cnt_reg + 3'd1;
                    if (issue_cnt_reg == BURST_CNT - 3'd1) begin
                        state_next = display_mem_pkg::DRAIN;
                    end
                end
            end
            display_mem_pkg::DRAIN: begin
                // ret_cnt reaches the burst length in the acknowledge cycle;
                // the following cycle is IDLE.
                if (ret_cnt_reg == BURST_CNT) begin
                    state_next = display_mem_pkg::IDLE;
                end
            end
            default: begin
                state_next = display_mem_pkg::IDLE;
            end
        endcase

        // Only returns matching an already accepted read are forwarded; a
        // return in the same cycle as an accept belongs to an earlier read.
        if (state_reg != display_mem_pkg::IDLE && mem_rvalid &&
            issue_cnt_reg != ret_cnt_reg) begin
            dout_next         = mem_rdata;
            beat_next[ch_reg] = 1'b1;
            ret_cnt_next      = ret_cnt_reg + 3'd1;
            if (ret_cnt_reg == BURST_CNT - 3'd1) begin
                ack_next[ch_reg] = 1'b1;
            end
        end
    end

    assign mem_addr         = {base_reg, widx_reg, 1'b0};
    assign dout             = dout_reg;
    assign burstdata_valid0 = beat_reg[0];
    assign burstdata_valid1 = beat_reg[1];
    assign bus_ack0         = ack_reg[0];
    assign bus_ack1         = ack_reg[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(beat_reg[0] && beat_reg[1]));
            assert (!(ack_reg[0] && ack_reg[1]));
        end
    end

endmodule

// File: tb/tb_display_burst_responder.sv
module tb_display_burst_responder;

    localparam int ADDR_W = 22;

    typedef struct {
        logic        ch;
        logic [15:0] data;
    } beat_t;

    typedef struct {
        logic ch;
        logic with_beat;
        int   nbeats;
    } ack_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] req_addr0 = '0;
    logic              req_as0 = 1'b0;
    logic              bus_ack0;
    logic              burstdata_valid0;
    logic [ADDR_W-1:0] req_addr1 = '0;
    logic              req_as1 = 1'b0;
    logic              bus_ack1;
    logic              burstdata_valid1;
    logic [15:0]       dout;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ready = 1'b0;
    logic [15:0]       mem_rdata = 16'd0;
    logic              mem_rvalid = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    // backend model state
    logic              p0_v = 1'b0, p1_v = 1'b0;
    logic [15:0]       p0_d = 16'd0, p1_d = 16'd0;
    logic              stall_mode = 1'b0;
    logic              inject_rv = 1'b0;
    logic              prev_pend = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    int                cyc = 0;
    int                hold_viol = 0;
    int                stall_cnt = 0;
    int                excl_viol = 0;
    logic [ADDR_W-1:0] acc_q[$];
    beat_t             beat_q[$];
    ack_t              ack_q[$];

    display_burst_responder #(.ADDR_W(ADDR_W), .BURST_WORDS(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_addr0        (req_addr0),
        .req_as0          (req_as0),
        .bus_ack0         (bus_ack0),
        .burstdata_valid0 (burstdata_valid0),
        .req_addr1        (req_addr1),
        .req_as1          (req_as1),
        .bus_ack1         (bus_ack1),
        .burstdata_valid1 (burstdata_valid1),
        .dout             (dout),
        .mem_addr         (mem_addr),
        .mem_rd           (mem_rd),
        .mem_ready        (mem_ready),
        .mem_rdata        (mem_rdata),
        .mem_rvalid       (mem_rvalid)
    );

    always #5 clk = ~clk;

    // Backend: read data = address + 0x5000, returned 2 cycles after accept.
    always @(posedge clk) begin
        #2;
        if (reset) begin
            p0_v = 1'b0;
            p1_v = 1'b0;
            mem_rvalid = 1'b0;
            mem_ready = 1'b0;
            prev_pend = 1'b0;
        end else begin
            if (prev_pend && !(mem_rd && mem_addr == prev_addr)) hold_viol++;
            mem_rvalid = p1_v;
            mem_rdata = p1_d;
            p1_v = p0_v;
            p1_d = p0_d;
            if (inject_rv) begin
                mem_rvalid = 1'b1;
                mem_rdata = 16'hDEAD;
                inject_rv = 1'b0;
            end
            mem_ready = stall_mode ? (cyc % 3 == 0) : 1'b1;
            cyc++;
            p0_v = mem_rd && mem_ready;
            p0_d = mem_addr[15:0] + 16'h5000;
            if (p0_v) acc_q.push_back(mem_addr);
            if (mem_rd && !mem_ready) stall_cnt++;
            prev_pend = mem_rd && !mem_ready;
            prev_addr = mem_addr;
        end
    end

    // Output monitor
    always @(posedge clk) begin
        #1;
        if (burstdata_valid0 || burstdata_valid1)
            beat_q.push_back('{ch: burstdata_valid1, data: dout});
        if (bus_ack0 || bus_ack1)
            ack_q.push_back('{ch: bus_ack1,
                              with_beat: bus_ack1 ? burstdata_valid1 : burstdata_valid0,
                              nbeats: beat_q.size()});
        if ((burstdata_valid0 && burstdata_valid1) || (bus_ack0 && bus_ack1)) excl_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic clear_logs();
        acc_q.delete();
        beat_q.delete();
        ack_q.delete();
    endtask

    task automatic wait_acks(input int target, input int budget);
        int n;
        n = 0;
        while (ack_q.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("ack_timeout", 32'(ack_q.size() >= target), 32'd1);
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n;
        n = 0;
        while (beat_q.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("beat_timeout", 32'(beat_q.size() >= target), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_as0 = 1'b0;
        req_as1 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Accepts, beats and the acknowledge of one burst against hand-made addresses.
    task automatic check_burst(input string tag, input logic ch,
                               input logic [3:0][ADDR_W-1:0] exp_addr);
        logic [ADDR_W-1:0] a;
        logic [15:0]       d;
        logic              c;
        chk({tag, "_accepts"}, 32'(acc_q.size()), 32'd4);
        chk({tag, "_beats"}, 32'(beat_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            a = (i < acc_q.size()) ? acc_q[i] : 'x;
            d = (i < beat_q.size()) ? beat_q[i].data : 'x;
            c = (i < beat_q.size()) ? beat_q[i].ch : 1'bx;
            chk($sformatf("%s_addr%0d", tag, i), 32'(a), 32'(exp_addr[i]));
            chk($sformatf("%s_data%0d", tag, i), 32'(d), 32'(exp_addr[i][15:0] + 16'h5000));
            chk($sformatf("%s_ch%0d", tag, i), 32'(c), 32'(ch));
        end
        chk({tag, "_acks"}, 32'(ack_q.size()), 32'd1);
        if (ack_q.size() > 0) begin
            chk({tag, "_ack_ch"}, 32'(ack_q[0].ch), 32'(ch));
            chk({tag, "_ack_with_beat"}, 32'(ack_q[0].with_beat), 32'd1);
            chk({tag, "_ack_on_4th"}, 32'(ack_q[0].nbeats), 32'd4);
        end
        $display("burst %s: ch%0d %0d accepts %0d beats %0d acks", tag, ch,
                 acc_q.size(), beat_q.size(), ack_q.size());
    endtask

    initial begin
        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_ack0", 32'(bus_ack0), 32'd0);
        chk("rst_ack1", 32'(bus_ack1), 32'd0);
        chk("rst_bdv0", 32'(burstdata_valid0), 32'd0);
        chk("rst_bdv1", 32'(burstdata_valid1), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ---- aligned burst on channel 0 ----
        clear_logs();
        req_addr0 = 22'h000100;
        req_as0 = 1'b1;
        wait_acks(1, 40);
        req_as0 = 1'b0;
        repeat (3) @(negedge clk);
        check_burst("aligned", 1'b0, {22'h000106, 22'h000104, 22'h000102, 22'h000100});
        chk("idle_mem_rd", 32'(mem_rd), 32'd0);

        // ---- stray mem_rvalid while idle is ignored ----
        inject_rv = 1'b1;
        repeat (4) @(negedge clk);
        chk("stray_no_beat", 32'(beat_q.size()), 32'd4);
        chk("stray_dout_kept", 32'(dout), 32'h5106);

        // ---- wrapping burst ----
        clear_logs();
        req_addr0 = 22'h000106;
        req_as0 = 1'b1;
        wait_acks(1, 40);
        req_as0 = 1'b0;
        repeat (3) @(negedge clk);
        check_burst("wrap", 1'b0, {22'h000104, 22'h000102, 22'h000100, 22'h000106});

        // ---- both channels from reset, ch0 re-requests immediately ----
        do_reset();
        clear_logs();
        req_addr0 = 22'h000040;
        req_addr1 = 22'h002000;
        req_as0 = 1'b1;
        req_as1 = 1'b1;
        wait_acks(1, 40);
        wait_acks(2, 40);
        req_as1 = 1'b0;
        wait_acks(3, 40);
        req_as0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rr_acks", 32'(ack_q.size()), 32'd3);
        chk("rr_first_ch", 32'(ack_q.size() > 0 ? ack_q[0].ch : 1'bx), 32'd0);
        chk("rr_second_ch", 32'(ack_q.size() > 1 ? ack_q[1].ch : 1'bx), 32'd1);
        chk("rr_third_ch", 32'(ack_q.size() > 2 ? ack_q[2].ch : 1'bx), 32'd0);
        chk("rr_ch1_addr0", 32'(acc_q.size() > 4 ? acc_q[4] : 'x), 32'h002000);
        chk("rr_ch1_addr3", 32'(acc_q.size() > 7 ? acc_q[7] : 'x), 32'h002006);
        chk("rr_ch0_again", 32'(acc_q.size() > 8 ? acc_q[8] : 'x), 32'h000040);
        chk("rr_ch1_beat_ch", 32'(beat_q.size() > 4 ? beat_q[4].ch : 1'bx), 32'd1);
        chk("rr_ch1_beat_data", 32'(beat_q.size() > 7 ? beat_q[7].data : 'x), 32'h7006);
        $display("round robin: ack order %0d acks", ack_q.size());

        // ---- backend back-pressure ----
        clear_logs();
        stall_cnt = 0;
        stall_mode = 1'b1;
        req_addr0 = 22'h000202;
        req_as0 = 1'b1;
        wait_acks(1, 80);
        req_as0 = 1'b0;
        repeat (3) @(negedge clk);
        stall_mode = 1'b0;
        check_burst("stall", 1'b0, {22'h000200, 22'h000206, 22'h000204, 22'h000202});
        chk("stall_hold_viol", 32'(hold_viol), 32'd0);
        chk("stall_seen", 32'(stall_cnt >= 6), 32'd1);

        // ---- requester drops strobe after first beat ----
        clear_logs();
        req_addr0 = 22'h000300;
        req_as0 = 1'b1;
        wait_beats(1, 40);
        req_as0 = 1'b0;
        wait_acks(1, 40);
        repeat (3) @(negedge clk);
        check_burst("drop_as", 1'b0, {22'h000306, 22'h000304, 22'h000302, 22'h000300});

        // ---- reset in the middle of a burst ----
        clear_logs();
        req_addr0 = 22'h000400;
        req_as0 = 1'b1;
        wait_beats(2, 40);
        reset = 1'b1;
        req_as0 = 1'b0;
        @(negedge clk);
        chk("mid_rst_ack0", 32'(bus_ack0), 32'd0);
        chk("mid_rst_bdv0", 32'(burstdata_valid0), 32'd0);
        chk("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("mid_rst_dout", 32'(dout), 32'd0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_fwd", 32'(beat_q.size()), 32'd2);
        chk("mid_rst_no_ack", 32'(ack_q.size()), 32'd0);
        chk("mid_rst_beat1", 32'(beat_q.size() > 1 ? beat_q[1].data : 'x), 32'h5402);

        clear_logs();
        req_addr1 = 22'h002008;
        req_as1 = 1'b1;
        wait_acks(1, 40);
        req_as1 = 1'b0;
        repeat (3) @(negedge clk);
        check_burst("after_rst", 1'b1, {22'h00200E, 22'h00200C, 22'h00200A, 22'h002008});

        chk("exclusive_strobes", 32'(excl_viol), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
